axi2per_req_channel: RTL and testbench

- Request stage of the AXI-to-peripheral bridge. Accepts single-beat AXI4 writes (AW+W) and reads (AR) and turns each into one 32-bit peripheral-interconnect request.
- Holds the request until the interconnect grants it.
- On grant, hands transfer type, ID and address to the downstream response stage and blocks until that stage reports completion.
- At most one transaction is in flight.

---
 rtl/axi2per_pkg.sv | 26 ++
 rtl/axi2per_req_arb.sv | 53 +++++
 rtl/axi2per_req_channel.sv | 153 +++++++++++++++
 tb/tb_axi2per_req_channel.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/axi2per_pkg.sv
// Shared types and constants for the AXI-to-peripheral request stage.
// The state encodings are fixed so that debug taps and checkers can decode them.
package axi2per_pkg;

  localparam int unsigned PER_DATA_WIDTH = 32;
  localparam int unsigned PER_BE_WIDTH   = PER_DATA_WIDTH / 8;

  localparam logic PER_WE_READ  = 1'b1;
  localparam logic PER_WE_WRITE = 1'b0;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    REQ       = ST_REQ,
    WAIT_RESP = ST_WAIT_RESP
  } req_state_e;

  typedef struct packed {
    logic wr;
    logic rd;
  } arb_grant_t;

endpackage

// File: rtl/axi2per_req_arb.sv
// Two-requester round-robin arbiter choosing between a pending AXI read and write.
// The winner is combinational; the history flops only advance on an accepted grant.
module axi2per_req_arb
  import axi2per_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rd_cand_i,
  input  logic       wr_cand_i,
  input  logic       accept_i,
  output arb_grant_t grant_o
);

  logic       last_was_write_q, last_was_write_d;
  logic       served_q, served_d;
  logic       tie_to_wr;
  arb_grant_t grant_d;

  // Until something has been served a tie goes to the read, as if a write came last.
  assign tie_to_wr = served_q && !last_was_write_q;

  always_comb begin
    grant_d          = '0;
    last_was_write_d = last_was_write_q;
    served_d         = served_q;
    if (accept_i) begin
      if (rd_cand_i && wr_cand_i) begin
        grant_d.wr = tie_to_wr;
        grant_d.rd = !tie_to_wr;
      end else begin
        grant_d.wr = wr_cand_i;
        grant_d.rd = rd_cand_i;
      end
      if (grant_d.wr || grant_d.rd) begin
        last_was_write_d = grant_d.wr;
        served_d         = 1'b1;
      end
    end
  end

  assign grant_o = grant_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_was_write_q <= 1'b0;
      served_q         <= 1'b0;
    end else begin
      last_was_write_q <= last_was_write_d;
      served_q         <= served_d;
    end
  end

endmodule

// File: rtl/axi2per_req_channel.sv
// Request stage of the AXI-to-peripheral bridge: one single-beat AXI read or write
// becomes one 32-bit peripheral request, with at most one transaction in flight.
module axi2per_req_channel
  import axi2per_pkg::*;
#(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,

  input  logic                        axi_slave_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
  output logic                        axi_slave_aw_ready_o,

  input  logic                        axi_slave_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
  output logic                        axi_slave_w_ready_o,

  input  logic                        axi_slave_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id_i,
  output logic                        axi_slave_ar_ready_o,

  output logic                        per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0]   per_master_add_o,
  output logic                        per_master_we_o,
  output logic [PER_DATA_WIDTH-1:0]   per_master_wdata_o,
  output logic [PER_BE_WIDTH-1:0]     per_master_be_o,
  output logic [PER_ID_WIDTH-1:0]     per_master_id_o,
  input  logic                        per_master_gnt_i,

  output logic                        trans_req_o,
  output logic                        trans_we_o,
  output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   trans_add_o,
  input  logic                        trans_r_valid_i
);

  // Handshake: an AXI ready is raised only in IDLE, combinationally, in the single
  // cycle the channel is accepted; per_master_req_o stays high from the cycle after
  // accept until the cycle in which per_master_gnt_i is seen, never withdrawn.

  // Unsupported widths elaborate this marker block so they are easy to spot.
  if (AXI_DATA_WIDTH != 64 || PER_ADDR_WIDTH != AXI_ADDR_WIDTH || AXI_USER_WIDTH == 0)
  begin : g_unsupported_cfg
    logic cfg_unsupported;
    assign cfg_unsupported = 1'b1;
  end

  req_state_e                  state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   add_q, add_d;
  logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
  logic                        we_q, we_d;
  logic [PER_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [PER_BE_WIDTH-1:0]     be_q, be_d;

  arb_grant_t                  grant;
  logic                        wr_cand;
  logic                        rd_cand;
  logic                        upper_lane;

  assign wr_cand    = axi_slave_aw_valid_i && axi_slave_w_valid_i;
  assign rd_cand    = axi_slave_ar_valid_i;
  assign upper_lane = axi_slave_aw_addr_i[2];

  axi2per_req_arb u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_cand_i (rd_cand),
    .wr_cand_i (wr_cand),
    .accept_i  (state_q == IDLE),
    .grant_o   (grant)
  );

  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    id_d    = id_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (grant.rd) begin
          add_d   = axi_slave_ar_addr_i;
          id_d    = axi_slave_ar_id_i;
          we_d    = PER_WE_READ;
          wdata_d = '0;
          be_d    = '1;
          state_d = REQ;
        end else if (grant.wr) begin
          add_d   = axi_slave_aw_addr_i;
          id_d    = axi_slave_aw_id_i;
          we_d    = PER_WE_WRITE;
          wdata_d = upper_lane ? axi_slave_w_data_i[2*PER_DATA_WIDTH-1:PER_DATA_WIDTH]
                               : axi_slave_w_data_i[PER_DATA_WIDTH-1:0];
          be_d    = upper_lane ? axi_slave_w_strb_i[2*PER_BE_WIDTH-1:PER_BE_WIDTH]
                               : axi_slave_w_strb_i[PER_BE_WIDTH-1:0];
          state_d = REQ;
        end
      end
      REQ: begin
        if (per_master_gnt_i) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (trans_r_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      add_q   <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      id_q    <= id_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign axi_slave_aw_ready_o = grant.wr;
  assign axi_slave_w_ready_o  = grant.wr;
  assign axi_slave_ar_ready_o = grant.rd;

  assign per_master_req_o   = (state_q == REQ);
  assign per_master_add_o   = add_q;
  assign per_master_we_o    = we_q;
  assign per_master_wdata_o = wdata_q;
  assign per_master_be_o    = be_q;
  assign per_master_id_o    = '0;

  assign trans_req_o = per_master_req_o && per_master_gnt_i;
  assign trans_we_o  = we_q;
  assign trans_id_o  = id_q;
  assign trans_add_o = add_q;

endmodule

// File: tb/tb_axi2per_req_channel.sv
// Bench for axi2per_req_channel: a driver issues AXI reads/writes and grants, a
// reference model predicts the accepted transaction, a monitor checks the request.
module tb_axi2per_req_channel;
  import axi2per_pkg::*;

  localparam int EXP_W = 72; // {we, id[2:0], addr[31:0], wdata[31:0], be[3:0]}

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        aw_valid, w_valid, ar_valid;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_id, ar_id;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        aw_ready, w_ready, ar_ready;
  logic        per_req, per_we, per_gnt;
  logic [31:0] per_add, per_wdata;
  logic [3:0]  per_be;
  logic [4:0]  per_id;
  logic        trans_req, trans_we, trans_r_valid;
  logic [2:0]  trans_id;
  logic [31:0] trans_add;

  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit served_any = 0;
  bit prev_write = 0;

  always #5 clk = ~clk;

  axi2per_req_channel dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_addr_i(aw_addr),
    .axi_slave_aw_id_i(aw_id), .axi_slave_aw_ready_o(aw_ready),
    .axi_slave_w_valid_i(w_valid), .axi_slave_w_data_i(w_data),
    .axi_slave_w_strb_i(w_strb), .axi_slave_w_ready_o(w_ready),
    .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_addr_i(ar_addr),
    .axi_slave_ar_id_i(ar_id), .axi_slave_ar_ready_o(ar_ready),
    .per_master_req_o(per_req), .per_master_add_o(per_add),
    .per_master_we_o(per_we), .per_master_wdata_o(per_wdata),
    .per_master_be_o(per_be), .per_master_id_o(per_id),
    .per_master_gnt_i(per_gnt),
    .trans_req_o(trans_req), .trans_we_o(trans_we), .trans_id_o(trans_id),
    .trans_add_o(trans_add), .trans_r_valid_i(trans_r_valid)
  );

  task automatic check(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] model_txn(input bit is_rd, input logic [31:0] addr,
      input logic [2:0] id, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] dsh;
    logic [7:0]  ssh;
    if (is_rd) return {1'b1, id, addr, 32'h0, 4'hF};
    dsh = data >> (addr[2] ? 32 : 0);
    ssh = strb >> (addr[2] ? 4 : 0);
    return {1'b0, id, addr, dsh[31:0], ssh[3:0]};
  endfunction

  task automatic randomize_valids();
    aw_valid = 1'($urandom_range(0, 1));
    w_valid  = 1'($urandom_range(0, 1));
    ar_valid = 1'($urandom_range(0, 1));
    aw_addr  = $urandom;
    ar_addr  = $urandom;
  endtask

  // kind: 0 read, 1 write, 2 read+write together, 3 AW first and W one cycle later
  task automatic present_and_accept(input int kind, input logic [31:0] awa,
      input logic [31:0] ara, input logic [2:0] awid, input logic [2:0] arid,
      input logic [63:0] wd, input logic [7:0] ws);
    bit rd_c, wr_c, win_rd, win_wr;
    aw_addr = awa; ar_addr = ara; aw_id = awid; ar_id = arid;
    w_data = wd; w_strb = ws;
    aw_valid = (kind != 0);
    w_valid  = (kind == 1 || kind == 2);
    ar_valid = (kind == 0 || kind == 2);
    if (kind == 3) begin
      @(negedge clk);
      check("ready_without_w", {aw_ready, w_ready, ar_ready}, 0);
      check("req_without_w", per_req, 0);
      @(posedge clk); #1;
      w_valid = 1'b1;
    end
    rd_c = ar_valid;
    wr_c = aw_valid && w_valid;
    // Tie rule: serve the kind not served last; a read wins when nothing was served yet.
    win_rd = rd_c && (!wr_c || !served_any || prev_write);
    win_wr = wr_c && !win_rd;
    if (win_rd || win_wr) begin
      served_any = 1'b1;
      prev_write = win_wr;
      if (win_rd) exp_q.push_back(model_txn(1'b1, ara, arid, wd, ws));
      else        exp_q.push_back(model_txn(1'b0, awa, awid, wd, ws));
    end
    @(negedge clk);
    check("accept_ready", {aw_ready, w_ready, ar_ready}, {win_wr, win_wr, win_rd});
    check("accept_idle", {per_req, 2'(dut.state_q)}, {1'b0, 2'(IDLE)});
    @(posedge clk); #1;
    randomize_valids();
  endtask

  task automatic finish_txn(input int gnt_delay, input int resp_delay);
    for (int i = 0; i <= gnt_delay; i++) begin
      per_gnt = (i == gnt_delay);
      trans_r_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("busy_req", {aw_ready, w_ready, ar_ready, per_req}, 4'b0001);
      @(posedge clk); #1;
    end
    per_gnt = 1'b0;
    for (int j = 0; j <= resp_delay; j++) begin
      trans_r_valid = (j == resp_delay);
      @(negedge clk);
      check("wait_resp", {aw_ready, w_ready, ar_ready, per_req, 2'(dut.state_q)},
            {4'b0000, 2'(WAIT_RESP)});
      @(posedge clk); #1;
    end
    trans_r_valid = 1'b0;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
  endtask

  task automatic issue(input int kind, input logic [31:0] awa, input logic [31:0] ara,
      input logic [2:0] awid, input logic [2:0] arid, input logic [63:0] wd,
      input logic [7:0] ws, input int gd, input int rd);
    present_and_accept(kind, awa, ara, awid, arid, wd, ws);
    finish_txn(gd, rd);
  endtask

  // Monitor: while a request is up its fields must match the head of the queue;
  // the granted cycle must carry the trans pulse and retires the entry.
  always @(negedge clk) begin
    logic [EXP_W-1:0] h;
    if (per_req) begin
      if (exp_q.size() == 0) begin
        check("req_unexpected", per_req, 0);
      end else begin
        h = exp_q[0];
        check("req_fields", {per_we, per_id, per_add, per_wdata, per_be},
              {h[71], 5'b0, h[67:36], h[35:4], h[3:0]});
        if (per_gnt) begin
          check("trans_pulse", {trans_req, trans_we, trans_id, trans_add},
                {1'b1, h[71], h[70:68], h[67:36]});
          void'(exp_q.pop_front());
        end else begin
          check("trans_quiet", trans_req, 0);
        end
      end
    end else if (trans_req) begin
      check("trans_spurious", trans_req, 0);
    end
  end

  initial begin
    rst_ni = 1'b0;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    aw_addr = 0; ar_addr = 0; aw_id = 0; ar_id = 0; w_data = 0; w_strb = 0;
    per_gnt = 0; trans_r_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {aw_ready, w_ready, ar_ready, per_req, per_add, per_we,
                            per_wdata, per_be, per_id, trans_req, trans_we, trans_id,
                            trans_add}, 0);
    check("reset_state", 2'(dut.state_q), 2'(IDLE));
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Both candidates held: expect read, write, read, write
    for (int k = 0; k < 4; k++)
      issue(2, 32'h3000_0000 + 32'(k*4), 32'h4000_0000 + 32'(k*4), 3'(k), 3'(k+4),
            64'h0123_4567_89AB_CDEF, 8'h5A, 0, 0);

    issue(0, 32'h0, 32'h1000_0004, 3'd0, 3'd3, 64'h0, 8'h0, 0, 0);
    issue(1, 32'h2000_0000, 32'h0, 3'd1, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF3, 0, 0);
    issue(1, 32'h2000_0004, 32'h0, 3'd2, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF3, 0, 0);
    issue(1, 32'h2000_0008, 32'h0, 3'd5, 3'd0, 64'h1111_2222_3333_4444, 8'h0F, 5, 2);
    issue(3, 32'h5000_000C, 32'h0, 3'd6, 3'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hC9, 1, 0);

    // Reset pulse while the request waits for a grant drops the transaction
    present_and_accept(0, 32'h0, 32'h6000_0010, 3'd0, 3'd7, 64'h0, 8'h0);
    per_gnt = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    exp_q.delete();
    served_any = 1'b0;
    prev_write = 1'b0;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    @(negedge clk);
    check("reset_in_req", {per_req, trans_req, 2'(dut.state_q)}, {2'b00, 2'(IDLE)});
    @(posedge clk); #1;
    issue(0, 32'h0, 32'h7000_0020, 3'd0, 3'd4, 64'h0, 8'h0, 1, 1);

    for (int n = 0; n < 150; n++)
      issue($urandom_range(0, 3), $urandom, $urandom, 3'($urandom), 3'($urandom),
            {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 4),
            $urandom_range(0, 3));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
